// File: rtl/minesweeper_pkg.sv
// Shared scan-code constants and PS/2 frame FSM encoding for the minesweeper
// keyboard path. The datapath compares against the same constants.
package minesweeper_pkg;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_DATA   = 2'd1,
    FS_PARITY = 2'd2,
    FS_STOP   = 2'd3
  } frameState_t;

endpackage

// File: rtl/ps2_input_conditioner.sv
// Synchronises the raw PS/2 lines, debounces the clock and emits a one-cycle
// strobe on each falling edge of the filtered clock.
module ps2_input_conditioner #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic strobe,
  output logic data_sync
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             clkMeta;
  logic             clkSync;
  logic             dataMeta;
  logic             filtLevel;
  logic [CNT_W-1:0] filtCnt;

  // Lines idle high, so every stage resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkMeta   <= 1'b1;
      clkSync   <= 1'b1;
      dataMeta  <= 1'b1;
      data_sync <= 1'b1;
      filtLevel <= 1'b1;
      filtCnt   <= '0;
      strobe    <= 1'b0;
    end else begin
      clkMeta   <= ps2_clk;
      clkSync   <= clkMeta;
      dataMeta  <= ps2_data;
      data_sync <= dataMeta;
      strobe    <= 1'b0;
      if (clkSync == filtLevel) begin
        filtCnt <= '0;
      end else if (filtCnt == CNT_W'(FILTER_LEN - 1)) begin
        filtLevel <= clkSync;
        filtCnt   <= '0;
        strobe    <= filtLevel;
      end else begin
        filtCnt <= filtCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_receiver.sv
// PS/2 device-to-host frame receiver: strips E0/F0 prefixes and presents make
// codes through a held valid/ack handshake.
module ps2_keycode_receiver
  import minesweeper_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overrun,
  output logic       frame_error
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic        strobe;
  logic        dataBit;
  frameState_t frameState;
  logic [2:0]  bitCnt;
  logic [7:0]  shiftReg;
  logic        parityBit;
  logic [TO_W-1:0] toCnt;
  logic        byteValid;
  logic [7:0]  rxByte;
  logic        extPending;
  logic        brkPending;

  ps2_input_conditioner #(
    .FILTER_LEN(FILTER_LEN)
  ) uCond (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .strobe   (strobe),
    .data_sync(dataBit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameState  <= FS_IDLE;
      bitCnt      <= '0;
      shiftReg    <= '0;
      parityBit   <= 1'b0;
      toCnt       <= '0;
      byteValid   <= 1'b0;
      rxByte      <= '0;
      frame_error <= 1'b0;
    end else begin
      byteValid   <= 1'b0;
      frame_error <= 1'b0;
      if (strobe) begin
        toCnt <= '0;
      end else if (frameState != FS_IDLE) begin
        toCnt <= toCnt + 1'b1;
      end
      if (frameState != FS_IDLE && !strobe && toCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        frame_error <= 1'b1;
        frameState  <= FS_IDLE;
        toCnt       <= '0;
      end else if (strobe) begin
        case (frameState)
          FS_IDLE: begin
            if (!dataBit) begin
              frameState <= FS_DATA;
              bitCnt     <= '0;
            end
          end
          FS_DATA: begin
            shiftReg <= {dataBit, shiftReg[7:1]};
            if (bitCnt == 3'd7) begin
              frameState <= FS_PARITY;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
          FS_PARITY: begin
            parityBit  <= dataBit;
            frameState <= FS_STOP;
          end
          FS_STOP: begin
            if (dataBit && (^{shiftReg, parityBit})) begin
              byteValid <= 1'b1;
              rxByte    <= shiftReg;
            end else begin
              frame_error <= 1'b1;
            end
            frameState <= FS_IDLE;
          end
          default: frameState <= FS_IDLE;
        endcase
      end
    end
  end

  // A load in the same cycle as key_ack wins, so the new key stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code     <= '0;
      key_extended <= 1'b0;
      key_valid    <= 1'b0;
      overrun      <= 1'b0;
      extPending   <= 1'b0;
      brkPending   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (key_ack) begin
        key_valid <= 1'b0;
      end
      if (frame_error) begin
        extPending <= 1'b0;
        brkPending <= 1'b0;
      end else if (byteValid) begin
        if (rxByte == SC_EXT) begin
          extPending <= 1'b1;
        end else if (rxByte == SC_BREAK) begin
          brkPending <= 1'b1;
        end else if (brkPending) begin
          extPending <= 1'b0;
          brkPending <= 1'b0;
        end else begin
          key_code     <= rxByte;
          key_extended <= extPending;
          key_valid    <= 1'b1;
          extPending   <= 1'b0;
          overrun      <= key_valid && !key_ack;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// Directed bench for ps2_keycode_receiver: table of scan-code sequences plus
// hand-written glitch, timeout, overrun and mid-frame reset sequences.
module tb_ps2_keycode_receiver;
  import minesweeper_pkg::*;

  localparam int FILT = 8;
  localparam int TMO  = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       overrun;
  logic       frame_error;

  int nTests = 0;
  int nFail  = 0;
  int errCnt = 0;
  int ovrCnt = 0;
  int keyCnt = 0;
  int strobeCnt = 0;
  logic prevValid = 1'b0;

  ps2_keycode_receiver #(
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_code    (key_code),
    .key_extended(key_extended),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .overrun     (overrun),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_error) errCnt++;
    if (overrun) ovrCnt++;
    if (dut.uCond.strobe) strobeCnt++;
    if (key_valid && !prevValid) keyCnt++;
    prevValid = key_valid;
  end

  typedef struct {
    logic [2:0][7:0] bytes;
    int              n;
    bit              badLast;
    int              expKeys;
    int              expErr;
    logic [7:0]      expCode;
    logic            expExt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mkVec(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, int n,
                                 bit bad, int keys, int err, logic [7:0] code, logic ext);
    vec_t v;
    v.bytes[0] = b0; v.bytes[1] = b1; v.bytes[2] = b2;
    v.n = n; v.badLast = bad; v.expKeys = keys; v.expErr = err;
    v.expCode = code; v.expExt = ext;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ps2Bit(logic b);
    ps2_data = b;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic sendFrame(logic [7:0] b, bit badPar);
    logic par;
    par = (~^b) ^ badPar;
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(b[i]);
    ps2Bit(par);
    ps2Bit(1'b1);
    #1 ps2_data = 1'b1;
  endtask

  task automatic ackKey(string name);
    @(posedge clk);
    #1 key_ack = 1'b1;
    @(posedge clk);
    #1 key_ack = 1'b0;
    @(negedge clk);
    check({name, "_ack_clears"}, 32'(key_valid), 32'd0);
  endtask

  initial begin
    int k0, e0, o0, s0;
    vec_t v;
    bit seen;

    vecs[0]  = mkVec(8'h5A, 8'h00, 8'h00, 1, 0, 1, 0, 8'h5A, 1'b0);
    vecs[1]  = mkVec(8'hE0, 8'h75, 8'h00, 2, 0, 1, 0, 8'h75, 1'b1);
    vecs[2]  = mkVec(8'hE0, 8'hF0, 8'h75, 3, 0, 0, 0, 8'h00, 1'b0);
    vecs[3]  = mkVec(8'h6B, 8'h00, 8'h00, 1, 0, 1, 0, 8'h6B, 1'b0);
    vecs[4]  = mkVec(8'h6B, 8'h00, 8'h00, 1, 1, 0, 1, 8'h00, 1'b0);
    vecs[5]  = mkVec(8'h2B, 8'h00, 8'h00, 1, 0, 1, 0, 8'h2B, 1'b0);
    vecs[6]  = mkVec(8'hF0, 8'h5A, 8'h00, 2, 0, 0, 0, 8'h00, 1'b0);
    vecs[7]  = mkVec(8'h74, 8'h00, 8'h00, 1, 0, 1, 0, 8'h74, 1'b0);
    vecs[8]  = mkVec(8'h74, 8'h00, 8'h00, 1, 0, 1, 0, 8'h74, 1'b0);
    vecs[9]  = mkVec(8'hE0, 8'h74, 8'h00, 2, 0, 1, 0, 8'h74, 1'b1);
    vecs[10] = mkVec(8'hE0, 8'h6B, 8'h00, 2, 1, 0, 1, 8'h00, 1'b0);
    vecs[11] = mkVec(8'h75, 8'h00, 8'h00, 1, 0, 1, 0, 8'h75, 1'b0);

    waitCycles(3);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_ext", 32'(key_extended), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    #1 rst_n = 1'b1;
    waitCycles(5);

    for (int t = 0; t < 12; t++) begin
      v = vecs[t];
      k0 = keyCnt; e0 = errCnt;
      for (int j = 0; j < v.n; j++) sendFrame(v.bytes[j], v.badLast && (j == v.n - 1));
      waitCycles(5);
      check($sformatf("v%0d_keys", t), 32'(keyCnt - k0), 32'(v.expKeys));
      check($sformatf("v%0d_ferr", t), 32'(errCnt - e0), 32'(v.expErr));
      check($sformatf("v%0d_valid", t), 32'(key_valid), 32'(v.expKeys != 0));
      if (v.expKeys != 0) begin
        check($sformatf("v%0d_code", t), 32'(key_code), 32'(v.expCode));
        check($sformatf("v%0d_ext", t), 32'(key_extended), 32'(v.expExt));
        ackKey($sformatf("v%0d", t));
      end
    end

    // Short low glitches on ps2_clk in IDLE with data low must not start a frame.
    s0 = strobeCnt;
    ps2_data = 1'b0;
    @(posedge clk); #1 ps2_clk = 1'b0;
    @(posedge clk); #1 ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (FILT - 2) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    #1 ps2_data = 1'b1;
    waitCycles(2);
    check("glitch_strobes", 32'(strobeCnt - s0), 32'd0);
    check("glitch_idle", 32'(dut.frameState == FS_IDLE), 32'd1);

    // Abandoned frame after 4 data bits times out.
    e0 = errCnt;
    ps2Bit(1'b0);
    for (int i = 0; i < 4; i++) ps2Bit(1'b1);
    waitCycles(150);
    check("tmo_not_early", 32'(errCnt - e0), 32'd0);
    waitCycles(70);
    check("tmo_ferr", 32'(errCnt - e0), 32'd1);
    check("tmo_idle", 32'(dut.frameState == FS_IDLE), 32'd1);
    sendFrame(8'h72, 0);
    waitCycles(5);
    check("tmo_next_valid", 32'(key_valid), 32'd1);
    check("tmo_next_code", 32'(key_code), 32'h72);
    ackKey("tmo_next");

    // Overwrite of an unacknowledged key.
    o0 = ovrCnt;
    sendFrame(8'h74, 0);
    waitCycles(5);
    sendFrame(8'h72, 0);
    waitCycles(5);
    check("ovr_pulse", 32'(ovrCnt - o0), 32'd1);
    check("ovr_code", 32'(key_code), 32'h72);
    check("ovr_valid", 32'(key_valid), 32'd1);
    ackKey("ovr");

    // Same again but key_ack coincides with the load cycle: no overrun.
    o0 = ovrCnt;
    sendFrame(8'h74, 0);
    waitCycles(5);
    seen = 1'b0;
    fork
      sendFrame(8'h72, 0);
      begin
        for (int i = 0; i < 2000 && !seen; i++) begin
          @(negedge clk);
          if (dut.byteValid) seen = 1'b1;
        end
        key_ack = 1'b1;
        @(posedge clk);
        #1 key_ack = 1'b0;
      end
    join
    check("ackload_seen", 32'(seen), 32'd1);
    waitCycles(2);
    check("ackload_no_ovr", 32'(ovrCnt - o0), 32'd0);
    check("ackload_valid", 32'(key_valid), 32'd1);
    check("ackload_code", 32'(key_code), 32'h72);
    ackKey("ackload");

    // Reset mid-frame with a key held and an E0 pending.
    sendFrame(8'h5A, 0);
    sendFrame(8'hE0, 0);
    ps2Bit(1'b0);
    for (int i = 0; i < 5; i++) ps2Bit(1'b1);
    #1 rst_n = 1'b0;
    waitCycles(2);
    check("mid_rst_code", 32'(key_code), 32'd0);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    check("mid_rst_ext", 32'(key_extended), 32'd0);
    check("mid_rst_idle", 32'(dut.frameState == FS_IDLE), 32'd1);
    #1 rst_n = 1'b1;
    ps2_data = 1'b1;
    waitCycles(5);
    sendFrame(8'h6B, 0);
    waitCycles(5);
    check("post_rst_valid", 32'(key_valid), 32'd1);
    check("post_rst_code", 32'(key_code), 32'h6B);
    check("post_rst_ext", 32'(key_extended), 32'd0);
    ackKey("post_rst");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
